// File: rtl/btn_debounce_bit.sv
// One button channel: two-flop synchronizer, debounce counter and accepted level,
// plus a single-cycle pulse on each accepted rising level.
module btn_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse,
  output logic pulse_next,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          stable_reg;
  logic          stable_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          pulse_reg;
  logic          accept;

  // A new level is taken only after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
  always_comb begin
    accept      = (s2_reg != stable_reg) && (cnt_reg == CNT_MAX);
    stable_next = stable_reg;
    cnt_next    = '0;
    pulse_next  = 1'b0;
    if (s2_reg != stable_reg) begin
      if (accept) begin
        stable_next = s2_reg;
        pulse_next  = s2_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      pulse_reg  <= 1'b0;
    end else begin
      s1_reg     <= btn;
      s2_reg     <= s1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      pulse_reg  <= pulse_next;
    end
  end

  assign pulse = pulse_reg;
  assign level = stable_reg;

endmodule

// File: rtl/btn_toggle_pulse_gen.sv
// Turns raw bouncing buttons into single-cycle toggle requests (t/en) for a
// downstream toggle register, plus debounced levels for status LEDs.
module btn_toggle_pulse_gen #(
  parameter int SIZE            = 4,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SIZE-1:0] btn,
  output logic [SIZE-1:0] t,
  output logic            en,
  output logic [SIZE-1:0] level
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_toggle_pulse_gen: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [SIZE-1:0] t_next;
  logic            en_reg;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
    btn_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn        (btn[gi]),
      .pulse      (t[gi]),
      .pulse_next (t_next[gi]),
      .level      (level[gi])
    );
  end

  // Registered from the next-state pulses so en lines up with t in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_reg <= 1'b0;
    else          en_reg <= |t_next;
  end

  assign en = en_reg;

endmodule

// File: tb/tb_btn_toggle_pulse_gen.sv
// Scenario bench for btn_toggle_pulse_gen with SIZE=4, DEBOUNCE_CYCLES=4.
module tb_btn_toggle_pulse_gen;

  localparam int SIZE = 4;
  localparam int DB   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SIZE-1:0] btn;
  logic [SIZE-1:0] t;
  logic            en;
  logic [SIZE-1:0] level;

  typedef struct packed {
    logic [SIZE-1:0] t;
    logic            en;
    logic [SIZE-1:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  btn_toggle_pulse_gen #(.SIZE(SIZE), .DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn),
    .t       (t),
    .en      (en),
    .level   (level)
  );

  always #5 clk = ~clk;

  // Expected outputs for n edges after a stimulus change; the accept happens at
  // 0-based edge idx (6th edge: 2 sync edges + DB-1 count edges + accept edge).
  function automatic void plan(int n, int idx, logic [SIZE-1:0] tv,
                               logic [SIZE-1:0] lvl_old, logic [SIZE-1:0] lvl_new);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.t   = (k == idx) ? tv : '0;
      x.en  = (k == idx) && (tv != '0);
      x.lvl = (k >= idx) ? lvl_new : lvl_old;
      exp_q.push_back(x);
    end
  endfunction

  localparam int ACC = DB + 1;

  task automatic test_reset();
    reset_n = 1'b0;
    btn     = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: t=%b en=%b level=%b, required all 0", k, t, en, level);
      end
    end
    reset_n = 1'b1;
    plan(9, ACC, 4'hF, 4'h0, 4'hF);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_release_all();
    btn = 4'h0;
    plan(8, ACC, 4'h0, 4'hF, 4'h0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL release_all edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_release_all done");
  endtask

  task automatic test_clean_press();
    btn[0] = 1'b1;
    plan(20, ACC, 4'b0001, 4'h0, 4'b0001);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 4; k++) begin
      btn[1] = (k % 2 == 0);
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {4'h0, 1'b0, 4'b0001}) begin
        n_fail++;
        $display("FAIL bounce_phase edge %0d: t=%b en=%b level=%b, required t=0000 en=0 level=0001",
                 k, t, en, level);
      end
    end
    btn[1] = 1'b1;
    plan(10, ACC, 4'b0010, 4'b0001, 4'b0011);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL bounce_settle edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_bounce done");
  endtask

  task automatic test_glitch();
    btn[2] = 1'b1;
    plan(3, 99, 4'h0, 4'b0011, 4'b0011);
    for (int k = 0; exp_q.size() > 0; k++) begin
      if (k == 3) btn[2] = 1'b0;
      if (k == 2) plan(10, 99, 4'h0, 4'b0011, 4'b0011);
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL glitch edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_release_and_simultaneous();
    btn[0] = 1'b0;
    plan(8, ACC, 4'h0, 4'b0011, 4'b0010);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL release0 edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    btn[3:2] = 2'b11;
    plan(8, ACC, 4'b1100, 4'b0010, 4'b1110);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_release_and_simultaneous done");
  endtask

  task automatic test_reset_mid_count();
    btn[0] = 1'b1;
    plan(2, 99, 4'h0, 4'b1110, 4'b1110);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL midcount_pre edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({t, en, level} !== 9'b0) begin
      n_fail++;
      $display("FAIL midcount_async: t=%b en=%b level=%b, required all 0", t, en, level);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== 9'b0) begin
        n_fail++;
        $display("FAIL midcount_hold edge %0d: t=%b en=%b level=%b, required all 0", k, t, en, level);
      end
    end
    btn     = 4'h0;
    reset_n = 1'b1;
    plan(10, 99, 4'h0, 4'h0, 4'h0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if ({t, en, level} !== {e.t, e.en, e.lvl}) begin
        n_fail++;
        $display("FAIL midcount_after edge %0d: t=%b en=%b level=%b, required t=%b en=%b level=%b",
                 k, t, en, level, e.t, e.en, e.lvl);
      end
    end
    $display("test_reset_mid_count done");
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = 4'hF;
    @(posedge clk); #1;
    test_reset();
    test_release_all();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release_and_simultaneous();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_toggle_pulse_gen.md
# btn_toggle_pulse_gen

Upstream stage for the vector toggle flip-flop with enable and reset: it turns raw, bouncing, asynchronous push-button/switch inputs into clean single-cycle toggle requests. It drives the toggle register's `t` vector and `en` directly. Each input bit is synchronized, debounced and rising-edge detected, so one physical press toggles exactly one bit of the downstream register once.

## Interface
- `SIZE`, 4, number of button channels; must match the downstream toggle register width.
- `DEBOUNCE_CYCLES`, 1250000, clock cycles an input must hold a new level before it is accepted (10 ms at 125 MHz); legal range ≥ 2.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn`  in  SIZE  raw asynchronous button levels, active-high.
- `t`  out  SIZE  toggle request vector; bit i is high for exactly one cycle per accepted press of `btn[i]`.
- `en`  out  1  high in exactly the cycles where `t` is non-zero.
- `level`  out  SIZE  debounced level of each button, for status LEDs.

## Operation
- Per bit, a 2-flop synchronizer: `btn[i]` → `s1[i]` → `s2[i]`.
- Per bit, a debounce counter `cnt[i]` of width $clog2(DEBOUNCE_CYCLES) and an accepted level `stable[i]`.
  - `s2 == stable`: `cnt` clears to 0.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`. If `s2 == 1`, then `t[i] <= 1`; otherwise `t[i] <= 0`.
- `t[i]` is 0 in every other cycle.
- `en` is registered as the OR-reduction of the next-state `t`, so it is aligned with `t` in the same cycle.
- `level` is `stable`.
- Falling edges are accepted into `level` but never produce a `t` pulse.
- Bounces shorter than `DEBOUNCE_CYCLES` consecutive cycles clear `cnt` and are ignored.
- The counter never wraps: it saturates at the accept point and clears there.

## Timing
- Reset values while `reset_n` is low, applied asynchronously: `s1`, `s2`, `stable`, `cnt`, `t`, `en`, `level` are all 0.
- Latency: `btn[i]` rises before edge 0 and stays high. `s2[i]` is 1 after edge 1. `t[i]`, `en` and `level[i]` go high at edge `DEBOUNCE_CYCLES+1` and `t`/`en` drop at the following edge.
- Pulse width is always exactly one clock, however long the button is held.
- Simultaneous accepts on several bits in the same edge produce a multi-bit `t` with a single `en` cycle.
- Reset mid-count discards the partial count; no pulse is emitted.
- A button held through reset release is treated as a new press: `stable` is 0, so a pulse follows `DEBOUNCE_CYCLES+2` edges after release.
- Outputs are fully registered, with no combinational path from `btn` to `t`, `en` or `level`.

## Structure
- No shared package is needed. The counter width is a localparam derived with $clog2.
- One sub-module is natural: `btn_debounce_bit`, holding the synchronizer, counter, stable register and single-bit pulse. It is instantiated SIZE times in a generate loop.
- The top level ORs the per-bit pulses into `en`.
- An elaboration-time check rejects `DEBOUNCE_CYCLES < 2`.

## Test plan
Benches run with `DEBOUNCE_CYCLES=4` and `SIZE=4`.
- Reset: hold `reset_n=0` with `btn=4'hF` → `t=0`, `en=0`, `level=0` throughout. Release reset with `btn` still `4'hF` → `t=4'hF` and `en=1` for one cycle after `DEBOUNCE_CYCLES+2` edges.
- Clean press: `btn[0]` rises before edge 0 and is held for 20 cycles → `t=4'b0001`, `en=1` only in the cycle after edge 5; `level[0]=1` from edge 5.
- Bounce: `btn[1]` toggles 1,0,1,0 on successive cycles, then settles high → no pulse during the bounce; exactly one pulse 5 edges after the final rise.
- Glitch: `btn[2]` high for 3 cycles, then low → `t` stays 0 and `level[2]` stays 0.
- Release and simultaneous press: release `btn[0]` → `level[0]` falls, no pulse. Press `btn[3:2]` on the same cycle → one cycle of `t=4'b1100`, `en=1`.
- Reset mid-count: assert `reset_n=0` two cycles into a press → outputs 0 immediately, no pulse while reset is held.
